// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle grant tenure.
// A last-winner pointer rotates priority; lowest-set-bit isolation on the
// rotated request vector keeps the grant one-hot. A tenure ends on `last`,
// on the grantee dropping its request, or when the hold limit is reached.
// A new winner is chosen on the same edge, so no idle cycle is inserted.
module rr_hold_arbiter #(
    parameter  int WIDTH    = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] req,
    input  logic             last,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    // A zero MAX_HOLD still needs a legal, non-zero counter width.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  grant_reg, grant_next;
    logic              valid_reg, valid_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic [IDX_W-1:0]  ptr_reg,   ptr_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;

    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  masked_req;
    logic [WIDTH-1:0]  cand;
    logic [WIDTH-1:0]  win_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic              any_req;
    logic              owner_req;
    logic              limit_hit;
    logic              tenure_end;

    // Priority mask: only requesters strictly above the last winner.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign mask[gi] = (ptr_reg < IDX_W'(gi));
        end
    endgenerate

    assign masked_req = req & mask;
    assign cand       = (|masked_req) ? masked_req : req;
    assign win_onehot = cand & (~cand + WIDTH'(1));
    assign any_req    = |req;

    // Binary encode of the one-hot winner.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (win_onehot[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Tenure-end conditions for the current grantee.
    assign owner_req  = |(req & grant_reg);
    assign limit_hit  = (MAX_HOLD != 0) && (cnt_reg == CNT_W'(MAX_HOLD));
    assign tenure_end = last || !owner_req || limit_hit;

    // Timeout is decoded from the registered tenure state together with the
    // same-cycle last/req, so a coincident `last` suppresses it.
    assign timeout = (state_reg == BUSY) && limit_hit && !last && owner_req;

    assign grant       = grant_reg;
    assign grant_valid = valid_reg;
    assign grant_idx   = idx_reg;

    // Next-state logic: grant from idle, hold, hand over, or release.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        valid_next = valid_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                    grant_next = win_onehot;
                    valid_next = 1'b1;
                    idx_next   = win_idx;
                    ptr_next   = win_idx;
                    cnt_next   = CNT_W'(1);
                end
            end
            BUSY: begin
                if (tenure_end) begin
                    // ptr_reg already equals the current grantee here.
                    if (any_req) begin
                        grant_next = win_onehot;
                        valid_next = 1'b1;
                        idx_next   = win_idx;
                        ptr_next   = win_idx;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        valid_next = 1'b0;
                        idx_next   = '0;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset clears outputs and gives req[0] top priority.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            ptr_reg   <= IDX_W'(WIDTH - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter (WIDTH=4, MAX_HOLD=4).
// Reference model tracks owner / last winner / tenure length as integers and
// picks the next winner by scanning forward from the last winner.
module tb_rr_hold_arbiter;

    localparam int W  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic [W-1:0] req;
    logic         last;
    logic [W-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    int m_owner;        // -1 when idle
    int m_last_winner;
    int m_tenure;

    logic [7:0] exp_v;
    logic [7:0] got_v;

    rr_hold_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req         (req),
        .last        (last),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [W-1:0] r, input int from);
        for (int k = 1; k <= W; k++) begin
            int c;
            c = (from + k) % W;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Expected {grant, grant_valid, grant_idx, timeout} for current inputs.
    function automatic logic [7:0] model_out(input logic [W-1:0] r, input logic l);
        logic [3:0] g;
        logic       v;
        logic [1:0] ix;
        logic       to;
        g  = '0;
        v  = 1'b0;
        ix = '0;
        to = 1'b0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            v  = 1'b1;
            ix = 2'(m_owner);
            to = (m_tenure == MH) && !l && r[m_owner];
        end
        return {g, v, ix, to};
    endfunction

    task automatic model_reset();
        m_owner       = -1;
        m_last_winner = W - 1;
        m_tenure      = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic l);
        int w;
        if (m_owner < 0) begin
            w = pick(r, m_last_winner);
            if (w >= 0) begin
                m_owner = w; m_last_winner = w; m_tenure = 1;
            end
        end else if (l || !r[m_owner] || m_tenure == MH) begin
            w = pick(r, m_last_winner);
            if (w >= 0) begin
                m_owner = w; m_last_winner = w; m_tenure = 1;
            end else begin
                m_owner = -1; m_tenure = 0;
            end
        end else begin
            m_tenure++;
        end
    endtask

    // Set inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic [W-1:0] r, input logic l);
        req  = r;
        last = l;
        #1;
        exp_v = model_out(r, l);
        got_v = {grant, grant_valid, grant_idx, timeout};
    endtask

    // Advance one clock, updating the model with the inputs that were sampled.
    task automatic tick();
        $display("cyc %0d req=%b last=%b grant=%b idx=%0d to=%b",
                 cyc, req, last, grant, grant_idx, timeout);
        @(posedge clk);
        model_edge(req, last);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        req  = '0;
        last = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({grant, grant_valid, grant_idx, timeout} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got %b want %b",
                     {grant, grant_valid, grant_idx, timeout}, 8'h00);
        end
        nrst = 1'b1;
        drive(4'b0110, 1'b0);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL reset_idle got %b want %b", got_v, exp_v);
        end
        tick();
        drive(4'b0110, 1'b0);
        total++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_grant got %b/%0d/%b want 0010/1/1",
                     grant, grant_idx, grant_valid);
        end
        tick();
    endtask

    task automatic go_idle();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 1'b0);
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL idle cyc %0d got %b want %b", cyc, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        go_idle();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b1);
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL rotation cyc %0d got %b want %b", cyc, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        go_idle();
        for (int i = 0; i < 14; i++) begin
            drive(4'b0011, 1'b0);
            if (timeout === 1'b1) pulses++;
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL timeout cyc %0d got %b want %b", cyc, got_v, exp_v);
            end
            tick();
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL timeout_count got %0d want 3", pulses);
        end
    endtask

    task automatic test_drop();
        logic [W-1:0] seq [4];
        seq = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        go_idle();
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 1'b0);
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL drop cyc %0d got %b want %b", cyc, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_sole();
        go_idle();
        for (int i = 0; i < 20; i++) begin
            drive(4'b0001, (i < 8) ? (i % 2 == 1) : 1'b0);
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL sole cyc %0d got %b want %b", cyc, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            drive(r, ($urandom_range(0, 4) == 0));
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random cyc %0d req=%b got %b want %b",
                         cyc, req, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        drive(4'b0100, 1'b0);
        tick();
        drive(4'b0100, 1'b0);
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL mid_setup got %b want 0100", grant);
        end
        nrst = 1'b0;
        #1;
        total++;
        if ({grant, grant_valid, grant_idx, timeout} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got %b want %b",
                     {grant, grant_valid, grant_idx, timeout}, 8'h00);
        end
        nrst = 1'b1;
        model_reset();
        drive(4'b1001, 1'b0);
        tick();
        drive(4'b1001, 1'b0);
        total++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_grant got %b/%0d want 0001/0", grant, grant_idx);
        end
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL post_reset_model got %b want %b", got_v, exp_v);
        end
        tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rotation();
        test_timeout();
        test_drop();
        test_sole();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
